// File: rtl/fetch_ifu_pkg.sv
// rtl/fetch_ifu_pkg.sv - shared widths, defaults and types for the fetch unit
package fetch_ifu_pkg;

  localparam int          FETCH_PC_WIDTH        = 32;
  localparam int          FETCH_INSTR_WIDTH     = 32;
  localparam logic [31:0] FETCH_RESET_PC        = 32'h0000_0000;
  localparam int          FETCH_MAX_OUTSTANDING = 2;

  // What the fetch unit does with a response handshake in the current cycle.
  typedef enum logic [1:0] {
    RESP_NONE  = 2'd0,  // no response handshake
    RESP_DROP  = 2'd1,  // answer to a request issued before a redirect
    RESP_LOAD  = 2'd2,  // live answer, loaded into the output register
    RESP_STRAY = 2'd3   // nothing was owed; ignored
  } resp_act_e;

  // Counter width able to hold the values 0..n inclusive.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fetch_pc_fifo.sv
// rtl/fetch_pc_fifo.sv - small synchronous FIFO holding PCs of in-flight fetches
module fetch_pc_fifo
  import fetch_ifu_pkg::*;
#(
  parameter int WIDTH = FETCH_PC_WIDTH,
  parameter int DEPTH = FETCH_MAX_OUTSTANDING
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok;
  logic             pop_ok;

  // Pointers wrap explicitly so any depth works, not only powers of two.
  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) return '0;
    return p + AW'(1);
  endfunction

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign push_ok    = push_i && !full_o && !flush_i;
  assign pop_ok     = pop_i && !empty_o && !flush_i;
  assign pop_data_o = mem[rd_ptr_q];

  // Storage: written on accepted push, never reset (contents gated by count).
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= ptr_next(wr_ptr_q);
      if (pop_ok)  rd_ptr_q <= ptr_next(rd_ptr_q);
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/fetch_ifu.sv
// rtl/fetch_ifu.sv - instruction fetch initiator with PC tagging and redirect flush
module fetch_ifu
  import fetch_ifu_pkg::*;
#(
  parameter int                  PC_WIDTH        = FETCH_PC_WIDTH,
  parameter int                  INSTR_WIDTH     = FETCH_INSTR_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC        = PC_WIDTH'(FETCH_RESET_PC),
  parameter int                  MAX_OUTSTANDING = FETCH_MAX_OUTSTANDING
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   redirect_valid_i,
  input  logic [PC_WIDTH-1:0]    redirect_pc_i,
  output logic                   if_req_valid_o,
  input  logic                   if_req_ready_i,
  output logic [PC_WIDTH-1:0]    if_req_pc_o,
  input  logic                   if_resp_valid_i,
  output logic                   if_resp_ready_o,
  input  logic                   if_resp_err_i,
  input  logic [INSTR_WIDTH-1:0] if_resp_instr_i,
  output logic                   ifu_valid_o,
  input  logic                   ifu_ready_i,
  output logic [PC_WIDTH-1:0]    ifu_pc_o,
  output logic [INSTR_WIDTH-1:0] ifu_instr_o,
  output logic                   ifu_err_o
);

  localparam int CW = cnt_width(MAX_OUTSTANDING);
  localparam int IW = CW + 1;

  logic [PC_WIDTH-1:0]    pc_q;
  logic [CW-1:0]          outstanding_q;
  logic [CW-1:0]          drop_cnt_q;
  logic                   halted_q;
  logic                   out_valid_q;
  logic [PC_WIDTH-1:0]    out_pc_q;
  logic [INSTR_WIDTH-1:0] out_instr_q;
  logic                   out_err_q;

  logic [IW-1:0]          inflight;
  logic                   req_hs;
  logic                   resp_hs;
  resp_act_e              resp_act;
  logic                   resp_counted;
  logic                   bypass;
  logic [PC_WIDTH-1:0]    load_pc;
  logic [PC_WIDTH-1:0]    redirect_pc_aligned;

  logic                   fifo_push;
  logic                   fifo_pop;
  logic [PC_WIDTH-1:0]    fifo_pop_pc;
  logic                   fifo_full;
  logic                   fifo_empty;

  // Stale (to-be-dropped) requests still occupy responder slots, so they count here.
  assign inflight = IW'(outstanding_q) + IW'(drop_cnt_q);

  assign if_req_valid_o  = !rst_i && !halted_q && !redirect_valid_i
                           && (inflight < IW'(MAX_OUTSTANDING));
  assign if_req_pc_o     = pc_q;
  assign req_hs          = if_req_valid_o && if_req_ready_i;

  // Dropped responses never touch the output stage, so they need no space there.
  assign if_resp_ready_o = (drop_cnt_q != '0) || !out_valid_q || ifu_ready_i;
  assign resp_hs         = if_resp_valid_i && if_resp_ready_o;

  assign redirect_pc_aligned = redirect_pc_i & ~PC_WIDTH'(3);

  // Classify the response; a same-cycle responder may answer the request being issued now.
  always_comb begin
    resp_act = RESP_NONE;
    if (resp_hs) begin
      if (drop_cnt_q != '0)           resp_act = RESP_DROP;
      else if (!fifo_empty || req_hs) resp_act = RESP_LOAD;
      else                            resp_act = RESP_STRAY;
    end
  end

  assign bypass       = (resp_act == RESP_LOAD) && fifo_empty;
  assign resp_counted = (resp_act == RESP_DROP) || (resp_act == RESP_LOAD);
  assign load_pc      = fifo_empty ? pc_q : fifo_pop_pc;
  assign fifo_push    = req_hs && !bypass && !fifo_full;
  assign fifo_pop     = (resp_act == RESP_LOAD) && !fifo_empty;

  fetch_pc_fifo #(
    .WIDTH (PC_WIDTH),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pc_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (redirect_valid_i),
    .push_i      (fifo_push),
    .push_data_i (pc_q),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_pop_pc),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // PC, request/drop counters and halt flag; redirect outranks everything but reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      halted_q      <= 1'b0;
    end else if (redirect_valid_i) begin
      pc_q          <= redirect_pc_aligned;
      outstanding_q <= '0;
      drop_cnt_q    <= drop_cnt_q + outstanding_q - CW'(resp_counted);
      halted_q      <= 1'b0;
    end else begin
      if (req_hs) pc_q <= pc_q + PC_WIDTH'(4);
      outstanding_q <= outstanding_q + CW'(req_hs) - CW'(resp_act == RESP_LOAD);
      drop_cnt_q    <= drop_cnt_q - CW'(resp_act == RESP_DROP);
      if ((resp_act == RESP_LOAD) && if_resp_err_i) halted_q <= 1'b1;
    end
  end

  // One-entry output register toward decode; reload and drain can share a cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_instr_q <= '0;
      out_err_q   <= 1'b0;
    end else if (redirect_valid_i) begin
      out_valid_q <= 1'b0;
    end else if (resp_act == RESP_LOAD) begin
      out_valid_q <= 1'b1;
      out_pc_q    <= load_pc;
      out_instr_q <= if_resp_instr_i;
      out_err_q   <= if_resp_err_i;
    end else if (ifu_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  assign ifu_valid_o = out_valid_q;
  assign ifu_pc_o    = out_pc_q;
  assign ifu_instr_o = out_instr_q;
  assign ifu_err_o   = out_err_q;

  // A response nobody asked for points at a broken responder.
  stray_resp_a : assert property (@(posedge clk_i) disable iff (rst_i)
    resp_act != RESP_STRAY);

endmodule
